ex_div_ctrl: RTL and testbench
==============================

EX_DIV_CTRL -- requirements
Module: ex_div_ctrl

Interface
Parameters: none; fixed 32-bit operands.
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: start_i  input  1  divide request from EX; held high until ready_o seen.
REQ-004 SHALL have ports: signed_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept.
REQ-005 SHALL have ports: annul_i  input  1  cancel in-flight or requested divide (exception/flush).
REQ-006 SHALL have ports: opdata1_i  input  32  dividend; sampled at accept.
REQ-007 SHALL have ports: opdata2_i  input  32  divisor; sampled at accept.
REQ-008 SHALL have ports: result_o  output  64  {remainder[63:32], quotient[31:0]}.
REQ-009 SHALL have ports: ready_o  output  1  result_o valid.
REQ-010 SHALL have ports: stall_o  output  1  pipeline stall request to EX/ctrl.

Function
REQ-011 SHALL implement a 4-state FSM: FREE, BYZERO, ON, END.
REQ-012 FREE: accept when start_i=1 and annul_i=0; divisor==0 -> BYZERO, else -> ON.
REQ-013 At accept, SHALL latch signed_i, operand signs and operand magnitudes (two's-complement negate negative operands when signed_i=1; raw values when 0).
REQ-014 SHALL clear a 6-bit iteration counter at accept.
REQ-015 ON: one restoring-division step per cycle (shift partial remainder left 1, trial-subtract divisor magnitude, keep if non-negative, shift quotient bit in); counter increments each step.
REQ-016 SHALL leave ON for END after exactly 32 steps (counter reaching 32).
REQ-017 On the ON->END transition, SHALL register result_o with sign fix: quotient negated if signed_i and operand signs differ; remainder negated if signed_i and dividend negative.
REQ-018 BYZERO: SHALL last one cycle, then enter END with result_o = 64'h0.
REQ-019 END: ready_o=1 and result_o held stable; SHALL return to FREE when start_i=0, with ready_o=0 and result_o=0 from the next cycle.
REQ-020 Latency: start accepted in cycle N -> ON cycles N+1..N+32 -> ready_o=1 from cycle N+33; divide-by-zero -> ready_o=1 from cycle N+2.
REQ-021 stall_o SHALL be 1 in BYZERO and ON, and combinationally 1 in FREE during an accept cycle; 0 in END and otherwise.
REQ-022 annul_i=1 in BYZERO or ON SHALL force FREE next cycle, ready_o=0, result_o=0, no result produced.
REQ-023 annul_i=1 in FREE SHALL block accept even if start_i=1.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 (wrap), remainder 0; no trap.
REQ-025 start_i, opdata1_i and opdata2_i changes after accept SHALL have no effect until the next FREE.

Reset
REQ-026 When rst=0 at a clock edge: state=FREE, counter=0, ready_o=0, result_o=0, internal operand/remainder registers=0.
REQ-027 Reset SHALL override any state, including mid-ON, and any simultaneous start_i/annul_i.
REQ-028 stall_o SHALL be 0 while rst=0.

Verification
REQ-029 Unsigned 100/7, start at cycle N -> ready_o=1 at N+33, result_o={32'd2, 32'd14}; stall_o=1 cycles N..N+32.
REQ-030 Signed -7/2 -> result_o={32'hFFFFFFFF, 32'hFFFFFFFD}; signed 7/-2 -> {32'h00000001, 32'hFFFFFFFD}.
REQ-031 Divisor 0 (any dividend, either mode) -> BYZERO one cycle, ready_o=1 at N+2, result_o=64'h0.
REQ-032 annul_i pulsed at N+10 -> FREE at N+11, ready_o never asserts, stall_o=0 from N+11; new divide then accepted normally.
REQ-033 rst=0 at N+15 mid-ON -> all outputs 0 next cycle; subsequent 0x80000000/0xFFFFFFFF signed -> {32'h0, 32'h80000000}.
REQ-034 start_i held high 3 cycles in END -> ready_o and result_o stable all 3; start_i=0 -> ready_o=0 next cycle.

Source files
------------

// File: rtl/ex_div_ctrl_if.sv
// Handshake and operand bus between the EX stage and the multi-cycle divider.
interface ex_div_ctrl_if;
    logic        start_i;
    logic        signed_i;
    logic        annul_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    modport master (
        output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, stall_o
    );

    modport slave (
        input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        output result_o, ready_o, stall_o
    );
endinterface

// File: rtl/ex_div_ctrl.sv
// 32-bit restoring divider for the EX stage: one quotient bit per cycle,
// sign handled by dividing magnitudes and fixing signs on the final step.
module ex_div_ctrl (
    input  logic         clk,
    input  logic         rst,
    ex_div_ctrl_if.slave div
);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic        sgn_q, neg1_q, neg2_q;
    logic [31:0] dvs_q, quo_q, rem_q;
    logic [63:0] result_q;
    logic        ready_q;

    logic        accept, stall, last_step;
    logic        neg1, neg2, keep;
    logic [31:0] mag1, mag2;
    logic [32:0] trial;
    logic [31:0] rem_step, quo_step, rem_fix, quo_fix;

    // Operand magnitudes for accept, plus one restoring step on the live remainder.
    always_comb begin
        neg1      = div.signed_i & div.opdata1_i[31];
        neg2      = div.signed_i & div.opdata2_i[31];
        mag1      = neg1 ? (~div.opdata1_i + 32'd1) : div.opdata1_i;
        mag2      = neg2 ? (~div.opdata2_i + 32'd1) : div.opdata2_i;
        trial     = {rem_q, quo_q[31]};
        keep      = (trial >= {1'b0, dvs_q});
        rem_step  = keep ? (trial[31:0] - dvs_q) : trial[31:0];
        quo_step  = {quo_q[30:0], keep};
        quo_fix   = (sgn_q & (neg1_q ^ neg2_q)) ? (~quo_step + 32'd1) : quo_step;
        rem_fix   = (sgn_q & neg1_q) ? (~rem_step + 32'd1) : rem_step;
        last_step = (cnt == 6'd31);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FREE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        stall     = 1'b0;
        case (state)
            FREE: begin
                if (div.start_i && !div.annul_i) begin
                    accept    = 1'b1;
                    stall     = 1'b1;
                    state_nxt = (div.opdata2_i == 32'd0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                stall     = 1'b1;
                state_nxt = div.annul_i ? FREE : END;
            end
            ON: begin
                stall = 1'b1;
                if (div.annul_i) begin
                    state_nxt = FREE;
                end else if (last_step) begin
                    state_nxt = END;
                end
            end
            END: begin
                if (!div.start_i) begin
                    state_nxt = FREE;
                end
            end
            default: state_nxt = FREE;
        endcase
    end

    // Datapath: operands are captured only on accept, so later bus changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= 6'd0;
            sgn_q    <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            dvs_q    <= 32'd0;
            quo_q    <= 32'd0;
            rem_q    <= 32'd0;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    result_q <= 64'd0;
                    ready_q  <= 1'b0;
                    if (accept) begin
                        sgn_q  <= div.signed_i;
                        neg1_q <= neg1;
                        neg2_q <= neg2;
                        dvs_q  <= mag2;
                        quo_q  <= mag1;
                        rem_q  <= 32'd0;
                        cnt    <= 6'd0;
                    end
                end
                BYZERO: begin
                    result_q <= 64'd0;
                    ready_q  <= !div.annul_i;
                end
                ON: begin
                    if (!div.annul_i) begin
                        rem_q <= rem_step;
                        quo_q <= quo_step;
                        cnt   <= cnt + 6'd1;
                        if (last_step) begin
                            result_q <= {rem_fix, quo_fix};
                            ready_q  <= 1'b1;
                        end
                    end
                end
                END: begin
                    if (!div.start_i) begin
                        result_q <= 64'd0;
                        ready_q  <= 1'b0;
                    end
                end
                default: begin
                    result_q <= 64'd0;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign div.result_o = result_q;
    assign div.ready_o  = ready_q;
    assign div.stall_o  = stall & rst;
endmodule

// File: tb/tb_ex_div_ctrl.sv
// Bench for ex_div_ctrl: cycle-level behavioural model checked every cycle,
// plus directed divides with hand-computed results and latencies.
module tb_ex_div_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;

    ex_div_ctrl_if bus ();

    ex_div_ctrl dut (
        .clk (clk),
        .rst (rst),
        .div (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          m_busy   = 0;
    logic        m_ready  = 1'b0;
    logic [63:0] m_result = 64'd0;
    logic [63:0] m_pending = 64'd0;
    logic        model_on = 1'b0;

    function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic sgn, input logic annul,
                                 input logic [31:0] a, input logic [31:0] b);
        bus.start_i   = start;
        bus.signed_i  = sgn;
        bus.annul_i   = annul;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: a divide is just "busy for k cycles, then show the arithmetic answer".
    always @(posedge clk) begin
        if (!rst) begin
            m_busy   = 0;
            m_ready  = 1'b0;
            m_result = 64'd0;
            model_on = 1'b1;
        end else if (m_busy > 0) begin
            if (bus.annul_i) begin
                m_busy = 0;
            end else begin
                m_busy--;
                if (m_busy == 0) begin
                    m_ready  = 1'b1;
                    m_result = m_pending;
                end
            end
        end else if (m_ready) begin
            if (!bus.start_i) begin
                m_ready  = 1'b0;
                m_result = 64'd0;
            end
        end else if (bus.start_i && !bus.annul_i) begin
            m_pending = model_div(bus.signed_i, bus.opdata1_i, bus.opdata2_i);
            m_busy    = (bus.opdata2_i == 32'd0) ? 1 : 32;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("ready_o", {63'd0, bus.ready_o}, {63'd0, m_ready});
            checkOutput("result_o", bus.result_o, m_result);
            checkOutput("stall_o", {63'd0, bus.stall_o},
                        {63'd0, rst && (m_busy > 0 || (!m_ready && bus.start_i && !bus.annul_i))});
        end
    end

    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int lat;
        applyStimulus(1'b1, sgn, 1'b0, a, b);
        #1;
        checkOutput({name, "_stall_at_accept"}, {63'd0, bus.stall_o}, 64'd1);
        tick();
        lat = 1;
        applyStimulus(1'b1, sgn, 1'b0, ~a, b + 32'd5);
        while (!bus.ready_o && lat < 60) begin
            tick();
            lat++;
        end
        checkOutput({name, "_latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({name, "_result"}, bus.result_o, exp);
        repeat (2) tick();
        checkOutput({name, "_held_ready"}, {63'd0, bus.ready_o}, 64'd1);
        checkOutput({name, "_held_result"}, bus.result_o, exp);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        checkOutput({name, "_ready_drop"}, {63'd0, bus.ready_o}, 64'd0);
        checkOutput({name, "_result_clear"}, bus.result_o, 64'd0);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;
        repeat (3) tick();
        checkOutput("reset_ready", {63'd0, bus.ready_o}, 64'd0);
        checkOutput("reset_result", bus.result_o, 64'd0);
        checkOutput("reset_stall", {63'd0, bus.stall_o}, 64'd0);
        rst = 1'b1;
        tick();

        checkOutput("model_u_100_7", model_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        checkOutput("model_s_m7_2", model_div(1'b1, 32'hFFFFFFF9, 32'd2), {32'hFFFFFFFF, 32'hFFFFFFFD});
        checkOutput("model_s_7_m2", model_div(1'b1, 32'd7, 32'hFFFFFFFE), {32'h00000001, 32'hFFFFFFFD});
        checkOutput("model_s_wrap", model_div(1'b1, 32'h80000000, 32'hFFFFFFFF), {32'h0, 32'h80000000});

        run_div("u_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
        run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 33);
        run_div("u_zero", 1'b0, 32'd12345, 32'd0, 64'd0, 2);
        run_div("s_zero", 1'b1, 32'hFFFFFFFB, 32'd0, 64'd0, 2);
        run_div("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 33);
        run_div("u_5_9", 1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 33);

        // Annul mid-divide: FREE again one cycle later, no result ever shown.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd1000, 32'd3);
        repeat (10) tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("annul_stall", {63'd0, bus.stall_o}, 64'd0);
        checkOutput("annul_ready", {63'd0, bus.ready_o}, 64'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.ready_o) seen = 1;
        end
        checkOutput("annul_no_ready", 64'(seen), 64'd0);
        run_div("after_annul", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33);

        // Annul held in FREE blocks the accept.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'd50, 32'd5);
        #1;
        checkOutput("free_annul_stall", {63'd0, bus.stall_o}, 64'd0);
        repeat (2) tick();
        checkOutput("free_annul_ready", {63'd0, bus.ready_o}, 64'd0);
        run_div("after_free_annul", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33);

        // Reset mid-divide, then the signed overflow case.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'hFFFFFF9C, 32'd7);
        repeat (15) tick();
        rst = 1'b0;
        tick();
        checkOutput("midrst_ready", {63'd0, bus.ready_o}, 64'd0);
        checkOutput("midrst_result", bus.result_o, 64'd0);
        checkOutput("midrst_stall", {63'd0, bus.stall_o}, 64'd0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        run_div("s_wrap", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
